// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: sync/DE timing, logical pixel requests and aligned colour output.
// Optional VGA_TIMING_TESTPATTERN_EN replaces pix_in with an internal 8-bar colour pattern.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int H_REPEAT    = 1,
  parameter int V_REPEAT    = 1,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int COLOR_BITS  = 4,
  parameter int PIX_LATENCY = 1,
  parameter int FC_W        = 8,
  localparam int XW = (H_ACTIVE / H_REPEAT > 1) ? $clog2(H_ACTIVE / H_REPEAT) : 1,
  localparam int YW = (V_ACTIVE / V_REPEAT > 1) ? $clog2(V_ACTIVE / V_REPEAT) : 1
) (
  input  logic                      clk_25_175,
  input  logic                      reset,
  output logic                      req_valid,
  output logic [XW-1:0]             req_x,
  output logic [YW-1:0]             req_y,
  input  logic [3*COLOR_BITS-1:0]   pix_in,
  output logic [COLOR_BITS-1:0]     r,
  output logic [COLOR_BITS-1:0]     g,
  output logic [COLOR_BITS-1:0]     b,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic                      line_start,
  output logic                      frame_start,
  output logic [FC_W-1:0]           frame_count
);
  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW    = $clog2(H_TOT);
  localparam int VCW    = $clog2(V_TOT);
  localparam int HS_ON  = H_ACTIVE + H_FP;
  localparam int HS_OFF = HS_ON + H_SYNC;
  localparam int VS_ON  = V_ACTIVE + V_FP;
  localparam int VS_OFF = VS_ON + V_SYNC;
  localparam int CB     = COLOR_BITS;
`ifdef VGA_TIMING_TESTPATTERN_EN
  localparam int CW     = 8;
  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BCW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
`else
  localparam int CW     = 5;
`endif
  // Control word layout: {bar[2:0] (pattern only), frame_start, line_start, vsync, hsync, de}
  localparam logic [CW-1:0] CTL_IDLE = {{(CW-3){1'b0}}, !VSYNC_POL, !HSYNC_POL, 1'b0};

  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [VCW-1:0] vcnt_q, vcnt_d;
  logic [2:0]     hsub_q, hsub_d, vsub_q, vsub_d;
  logic [XW-1:0]  lx_q, lx_d;
  logic [YW-1:0]  ly_q, ly_d;
  logic           h_wrap, v_wrap, h_act, v_act, act;
  logic [CW-1:0]  ctl_d;
  logic [CW-1:0]  pipe_q [PIX_LATENCY+1];
  logic [CW-1:0]  tail;

  assign h_wrap = (hcnt_q == HCW'(H_TOT - 1));
  assign v_wrap = (vcnt_q == VCW'(V_TOT - 1));
  assign h_act  = (hcnt_q < HCW'(H_ACTIVE));
  assign v_act  = (vcnt_q < VCW'(V_ACTIVE));
  assign act    = h_act && v_act;
  assign tail   = pipe_q[PIX_LATENCY];

`ifdef VGA_TIMING_TESTPATTERN_EN
  logic [BCW-1:0] bsub_q, bsub_d;
  logic [2:0]     bar_q, bar_d;
  logic           unused_pix;
  assign unused_pix = ^pix_in;
`endif

  always_comb begin
    hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    hsub_d = hsub_q;
    lx_d   = lx_q;
    vsub_d = vsub_q;
    ly_d   = ly_q;
    if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
    // Logical x restarts at the last active clock so blanking always presents x=0.
    if (h_wrap || hcnt_q == HCW'(H_ACTIVE - 1)) begin
      hsub_d = '0;
      lx_d   = '0;
    end else if (h_act) begin
      if (hsub_q == 3'(H_REPEAT - 1)) begin
        hsub_d = '0;
        lx_d   = lx_q + 1'b1;
      end else begin
        hsub_d = hsub_q + 1'b1;
      end
    end
    if (h_wrap) begin
      if (v_wrap || vcnt_q == VCW'(V_ACTIVE - 1)) begin
        vsub_d = '0;
        ly_d   = '0;
      end else if (v_act) begin
        if (vsub_q == 3'(V_REPEAT - 1)) begin
          vsub_d = '0;
          ly_d   = ly_q + 1'b1;
        end else begin
          vsub_d = vsub_q + 1'b1;
        end
      end
    end
  end

`ifdef VGA_TIMING_TESTPATTERN_EN
  always_comb begin
    bsub_d = bsub_q;
    bar_d  = bar_q;
    if (h_wrap || hcnt_q == HCW'(H_ACTIVE - 1)) begin
      bsub_d = '0;
      bar_d  = '0;
    end else if (h_act) begin
      if (bsub_q == BCW'(BAR_W - 1)) begin
        bsub_d = '0;
        bar_d  = bar_q + 1'b1;
      end else begin
        bsub_d = bsub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      bsub_q <= '0;
      bar_q  <= '0;
    end else begin
      bsub_q <= bsub_d;
      bar_q  <= bar_d;
    end
  end
`endif

  always_comb begin
    ctl_d    = CTL_IDLE;
    ctl_d[0] = act;
    ctl_d[1] = (hcnt_q >= HCW'(HS_ON) && hcnt_q < HCW'(HS_OFF)) ? HSYNC_POL : !HSYNC_POL;
    ctl_d[2] = (vcnt_q >= VCW'(VS_ON) && vcnt_q < VCW'(VS_OFF)) ? VSYNC_POL : !VSYNC_POL;
    ctl_d[3] = act && (hcnt_q == '0);
    ctl_d[4] = act && (hcnt_q == '0) && (vcnt_q == '0);
`ifdef VGA_TIMING_TESTPATTERN_EN
    ctl_d[7:5] = bar_q;
`endif
  end

  // Stage 0: raster counters and registered pixel request
  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hsub_q    <= '0;
      vsub_q    <= '0;
      lx_q      <= '0;
      ly_q      <= '0;
      req_valid <= 1'b0;
      req_x     <= '0;
      req_y     <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hsub_q    <= hsub_d;
      vsub_q    <= vsub_d;
      lx_q      <= lx_d;
      ly_q      <= ly_d;
      req_valid <= act;
      req_x     <= act ? lx_q : '0;
      req_y     <= act ? ly_q : '0;
    end
  end

  // Stages 1..PIX_LATENCY: control delay matching the frame-source fetch latency
  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      for (int i = 0; i <= PIX_LATENCY; i++) pipe_q[i] <= CTL_IDLE;
    end else begin
      pipe_q[0] <= ctl_d;
      for (int i = 1; i <= PIX_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Output stage: colour captured alongside the aligned control word
  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      de          <= 1'b0;
      hsync       <= !HSYNC_POL;
      vsync       <= !VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      de          <= tail[0];
      hsync       <= tail[1];
      vsync       <= tail[2];
      line_start  <= tail[3];
      frame_start <= tail[4];
      frame_count <= frame_count + FC_W'(tail[4]);
`ifdef VGA_TIMING_TESTPATTERN_EN
      r <= (tail[0] && tail[5]) ? '1 : '0;
      g <= (tail[0] && tail[6]) ? '1 : '0;
      b <= (tail[0] && tail[7]) ? '1 : '0;
`else
      r <= tail[0] ? pix_in[CB-1:0]      : '0;
      g <= tail[0] ? pix_in[2*CB-1:CB]   : '0;
      b <= tail[0] ? pix_in[3*CB-1:2*CB] : '0;
`endif
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster generator, the successor to the fixed 640x480 timing core. It produces sync and data-enable, plus a registered pixel request (x, y) to the frame source. It takes a colour word back after a configurable fetch latency. It supports pixel/line replication for low-resolution framebuffers, configurable sync polarity and colour depth, and frame/line strobes. It sits between the demo pixel generators and the VGA DAC pins.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal porches and sync width, in clocks
- V_ACTIVE, 480: visible lines
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porches and sync width, in lines
- H_REPEAT, 1: clocks per logical pixel; H_ACTIVE must be divisible by it; range 1..8
- V_REPEAT, 1: physical lines per logical line; V_ACTIVE must be divisible by it; range 1..8
- HSYNC_POL, 0 / VSYNC_POL, 0: active level of the sync pulses
- COLOR_BITS, 4: bits per channel
- PIX_LATENCY, 1: clocks from req to valid pix_in; range 0..4
- FC_W, 8: frame counter width
- clk_25_175  in  1  pixel clock
- reset  in  1  synchronous, active-low
- req_valid  out  1  a request for an active pixel is valid this cycle
- req_x  out  clog2(H_ACTIVE/H_REPEAT)  logical x
- req_y  out  clog2(V_ACTIVE/V_REPEAT)  logical y
- pix_in  in  3*COLOR_BITS  colour word: {b,g,r} with r in the LSBs
- r, g, b  out  COLOR_BITS each  colour output; 0 when de=0
- hsync, vsync  out  1  sync outputs
- de  out  1  active-video flag
- line_start  out  1  one-clock pulse coinciding with the first de=1 clock of each line
- frame_start  out  1  one-clock pulse coinciding with de=1 at pixel (0,0)
- frame_count  out  FC_W  number of completed frame_starts, modulo 2^FC_W

## Operation
- The raster counters are hcnt 0..H_TOT-1 and vcnt 0..V_TOT-1, where H_TOT is the sum of the H parameters and V_TOT is the sum of the V parameters.
- hcnt increments every clock and wraps to 0 at H_TOT-1.
- vcnt increments on the hcnt wrap and wraps to 0 at V_TOT-1 when hcnt also wraps.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- hsync is active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC. vsync follows the same rule using the V parameters.
- Logical coordinates come from sub-counters, never from a divider:
  - req_x steps once per H_REPEAT active clocks and is 0 at hcnt=0.
  - req_y steps once per V_REPEAT active lines and is 0 at vcnt=0.
- Outside the active region, req_valid=0. In that case req_x and req_y hold 0.
- A pixel pipeline of depth PIX_LATENCY+1 carries de, hsync, vsync, line_start and frame_start so that they stay aligned with colour.
- r, g and b are registered from pix_in, ANDed with the aligned de.
- frame_count increments on the clock edge that outputs frame_start=1 and wraps silently.

## Timing
- Let hcnt/vcnt hold value (h,v) in cycle t. Then:
  - req_* reflect (h,v) in cycle t+1.
  - pix_in for that request must be valid in cycle t+1+PIX_LATENCY.
  - r/g/b, de, sync and strobes for (h,v) appear in cycle t+2+PIX_LATENCY.
- All outputs are registered.
- Reset values:
  - hcnt, vcnt and all sub-counters are 0.
  - req_valid, req_x, req_y, r, g, b, de, line_start, frame_start and frame_count are 0.
  - hsync=!HSYNC_POL and vsync=!VSYNC_POL, and the whole pipeline is filled with these inactive values.
- First cycle after reset release: the counters are at (0,0). req_valid=1 in the following cycle.
- frame_start is first asserted PIX_LATENCY+2 clocks after release.
- Reset asserted mid-frame: all outputs take their reset values on the next edge. No partial pixels or sync pulses are emitted after that.
- Simultaneous hcnt wrap and vcnt wrap: both counters go to 0 on the same edge, and the y sub-counter clears with them.

## Configuration
- VGA_TIMING_TESTPATTERN_EN: when defined, pix_in is ignored and the colour comes from an internal pattern generated at the same pipeline position.
  - The pattern is 8 vertical bars, each H_ACTIVE/8 clocks wide.
  - Bar k, for k=0..7, sets r, g and b to all-ones when bit0, bit1 and bit2 of k respectively are set, and 0 otherwise.
  - req_* still operate normally.
- When not defined, colour comes from pix_in only, and the pattern logic is absent.

## Test plan
- Defaults, 2 frames after reset release:
  - de high 640 clocks per line.
  - Line period 800 clocks.
  - hsync low 96 clocks starting 656 clocks after each de rise.
  - vsync low for 2 lines beginning 490 lines after frame_start.
  - Frame period 420000 clocks.
- PIX_LATENCY=3, source drives pix_in = {2'b0, req_y[1:0], req_x[7:0]} delayed 3 clocks:
  - r/g/b at the de-rise of line 5, pixel 17, equal that encoding of (17,5).
  - No skew relative to de.
- H_REPEAT=4, V_REPEAT=2:
  - req_x goes 0..159, with each value held 4 clocks.
  - req_y goes 0..239, with each value held 2 lines.
  - req_valid drops at hcnt=640.
- HSYNC_POL=1, VSYNC_POL=1: sync idles low and pulses high, with widths identical to the default case.
- Reset held low for 3 clocks at hcnt=300, vcnt=100:
  - Outputs go to reset values, and no extra sync edge is produced.
  - frame_start arrives PIX_LATENCY+2 clocks after release.
  - frame_count resets to 0, then reads 1 after that frame_start.
- Macro defined, defaults: at line 0, pixel 85, rgb = F,0,0 (bar 1). At pixel 639, rgb = F,F,F.
